// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sizes, screen limits, sprite ids and scheduler states
package sprite_pkg;

    localparam int NUM_SPRITES = 3;
    localparam int X_W         = 10;
    localparam int Y_W         = 9;
    localparam int ID_W        = 2;

    // Legal on-screen window, inside the border
    localparam logic [X_W-1:0] X_MIN = 10'd11;
    localparam logic [X_W-1:0] X_MAX = 10'd619;
    localparam logic [Y_W-1:0] Y_MIN = 9'd11;
    localparam logic [Y_W-1:0] Y_MAX = 9'd459;

    localparam logic [ID_W-1:0] SPR_PLAYER = 2'd0;
    localparam logic [ID_W-1:0] SPR_ENEMY  = 2'd1;
    localparam logic [ID_W-1:0] SPR_BULLET = 2'd2;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_COMMIT = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/sprite_update_scheduler_if.sv
// rtl/sprite_update_scheduler_if.sv - position write request ports for the two requesters
interface sprite_update_scheduler_if;
    import sprite_pkg::*;

    logic            req0_valid;
    logic [ID_W-1:0] req0_id;
    logic [X_W-1:0]  req0_x;
    logic [Y_W-1:0]  req0_y;
    logic            req0_ready;

    logic            req1_valid;
    logic [ID_W-1:0] req1_id;
    logic [X_W-1:0]  req1_x;
    logic [Y_W-1:0]  req1_y;
    logic            req1_ready;

    // Requester side: processor on port 0, motion engine on port 1
    modport master (
        output req0_valid, req0_id, req0_x, req0_y,
        output req1_valid, req1_id, req1_x, req1_y,
        input  req0_ready, req1_ready
    );

    // Scheduler side
    modport slave (
        input  req0_valid, req0_id, req0_x, req0_y,
        input  req1_valid, req1_id, req1_x, req1_y,
        output req0_ready, req1_ready
    );

endinterface

// File: rtl/sprite_update_scheduler_rr_arbiter2.sv
// rtl/sprite_update_scheduler_rr_arbiter2.sv - two-way round-robin arbiter with last-grant memory
module rr_arbiter2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant
);

    // Port that won the most recent grant; reset to 1 so port 0 wins the first contest
    logic r_last;

    // Lone requester wins outright; a contest goes to the port not granted last
    always_comb begin
        o_grant = 2'b00;
        if (i_en) begin
            case (i_valid)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
                default: o_grant = 2'b00;
            endcase
        end
    end

    // Remember the winner of every grant
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last <= 1'b1;
        end else if (o_grant[0]) begin
            r_last <= 1'b0;
        end else if (o_grant[1]) begin
            r_last <= 1'b1;
        end
    end

endmodule

// File: rtl/sprite_update_scheduler.sv
// rtl/sprite_update_scheduler.sv - shadowed sprite positions committed to active at frame start
module sprite_update_scheduler
    import sprite_pkg::*;
(
    input  logic                         master_clk,
    input  logic                         reset,
    input  logic                         frame_start,
    sprite_update_scheduler_if.slave     bus,
    output logic [NUM_SPRITES*X_W-1:0]   active_x,
    output logic [NUM_SPRITES*Y_W-1:0]   active_y,
    output logic                         commit_done,
    output logic                         err_bad_id,
    output logic                         err_missed_frame
);

    state_t          r_state;
    state_t          w_state_next;
    logic [ID_W-1:0] r_idx;
    logic [ID_W-1:0] w_idx_next;

    logic [X_W-1:0]  r_shadow_x [NUM_SPRITES];
    logic [Y_W-1:0]  r_shadow_y [NUM_SPRITES];
    logic [X_W-1:0]  r_active_x [NUM_SPRITES];
    logic [Y_W-1:0]  r_active_y [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] r_dirty;
    logic            r_err_bad_id;
    logic            r_err_missed;

    logic            w_accept;
    logic [1:0]      w_grant;
    logic            w_wr_en;
    logic [ID_W-1:0] w_wr_id;
    logic [X_W-1:0]  w_wr_x;
    logic [Y_W-1:0]  w_wr_y;
    logic [X_W-1:0]  w_clamp_x;
    logic [Y_W-1:0]  w_clamp_y;
    logic            w_id_ok;

    assign w_accept = (r_state == ST_ACCEPT);

    rr_arbiter2 u_arb (
        .i_clk   (master_clk),
        .i_rst   (reset),
        .i_en    (w_accept),
        .i_valid ({bus.req1_valid, bus.req0_valid}),
        .o_grant (w_grant)
    );

    // A grant is only ever given to a valid port, so a grant is a transfer
    assign bus.req0_ready = w_grant[0];
    assign bus.req1_ready = w_grant[1];

    assign w_wr_en = |w_grant;
    assign w_wr_id = w_grant[1] ? bus.req1_id : bus.req0_id;
    assign w_wr_x  = w_grant[1] ? bus.req1_x  : bus.req0_x;
    assign w_wr_y  = w_grant[1] ? bus.req1_y  : bus.req0_y;
    assign w_id_ok = (w_wr_id < ID_W'(NUM_SPRITES));

    // Pull the requested position back inside the visible window
    always_comb begin
        w_clamp_x = w_wr_x;
        w_clamp_y = w_wr_y;
        if (w_wr_x < X_MIN) begin
            w_clamp_x = X_MIN;
        end else if (w_wr_x > X_MAX) begin
            w_clamp_x = X_MAX;
        end
        if (w_wr_y < Y_MIN) begin
            w_clamp_y = Y_MIN;
        end else if (w_wr_y > Y_MAX) begin
            w_clamp_y = Y_MAX;
        end
    end

    // State and commit index register
    always_ff @(posedge master_clk) begin
        if (reset) begin
            r_state <= ST_ACCEPT;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // Next state: accept writes until frame start, walk sprites one per cycle, then flag done
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            ST_ACCEPT: begin
                if (frame_start) begin
                    w_state_next = ST_COMMIT;
                    w_idx_next   = '0;
                end
            end
            ST_COMMIT: begin
                if (r_idx == ID_W'(NUM_SPRITES - 1)) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_idx_next = r_idx + 1'b1;
                end
            end
            ST_DONE: begin
                w_state_next = ST_ACCEPT;
            end
            default: begin
                w_state_next = ST_ACCEPT;
            end
        endcase
    end

    // Shadow writes in ACCEPT and shadow-to-active copies in COMMIT never overlap in time
    always_ff @(posedge master_clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_shadow_x[i] <= X_MIN;
                r_shadow_y[i] <= Y_MIN;
                r_active_x[i] <= X_MIN;
                r_active_y[i] <= Y_MIN;
            end
            r_dirty <= '0;
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (w_wr_en && w_id_ok && (w_wr_id == ID_W'(i))) begin
                    r_shadow_x[i] <= w_clamp_x;
                    r_shadow_y[i] <= w_clamp_y;
                    r_dirty[i]    <= 1'b1;
                end
                if ((r_state == ST_COMMIT) && (r_idx == ID_W'(i)) && r_dirty[i]) begin
                    r_active_x[i] <= r_shadow_x[i];
                    r_active_y[i] <= r_shadow_y[i];
                    r_dirty[i]    <= 1'b0;
                end
            end
        end
    end

    // Sticky error flags
    always_ff @(posedge master_clk) begin
        if (reset) begin
            r_err_bad_id <= 1'b0;
            r_err_missed <= 1'b0;
        end else begin
            if (w_wr_en && !w_id_ok) begin
                r_err_bad_id <= 1'b1;
            end
            if (frame_start && !w_accept) begin
                r_err_missed <= 1'b1;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_SPRITES; g++) begin : g_pack
            assign active_x[g*X_W +: X_W] = r_active_x[g];
            assign active_y[g*Y_W +: Y_W] = r_active_y[g];
        end
    endgenerate

    assign commit_done      = (r_state == ST_DONE);
    assign err_bad_id       = r_err_bad_id;
    assign err_missed_frame = r_err_missed;

endmodule
